pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: width of PC and all target buses.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Port clk input 1: single clock; all state updates on rising edge.
REQ-004 Port rst input 1: synchronous, active-high reset.
REQ-005 Port StallF input 1: hold PCF; fetch stage stalled.
REQ-006 Port PCSrcE input 1: branch/jump taken, resolved in EX.
REQ-007 Port JumpTarget_E input XLEN: branch/jump target.
REQ-008 Port TrapE input 1: trap request (PC_TRAP_EN builds only).
REQ-009 Port TrapVec input XLEN: trap handler address (PC_TRAP_EN builds only).
REQ-010 Port PCF output XLEN: registered fetch PC.
REQ-011 Port PCplus4F output XLEN: PCF + 4, combinational.
REQ-012 Port RedirectPend output 1: a redirect is captured and waiting for the stall to release.
REQ-013 Port MisalignF output 1: registered one-cycle pulse; the applied target had bits [1:0] != 0.

Function
REQ-014 Source priority, highest first: TrapE, PCSrcE, pending redirect, PCplus4F.
REQ-015 FSM states: RUN, HOLD.
REQ-016 RUN, StallF=0: PCF <= highest-priority source next edge; latency from redirect input to PCF is one cycle.
REQ-017 RUN, StallF=1, no redirect: PCF holds; state stays RUN.
REQ-018 RUN, StallF=1 with TrapE or PCSrcE: target captured into pending register; PCF holds; next state HOLD.
REQ-019 HOLD, StallF=1: PCF holds; a new TrapE/PCSrcE overwrites the pending target; otherwise the pending target is kept.
REQ-020 HOLD, StallF=0: PCF <= new TrapE/PCSrcE target if present, else the pending target; next state RUN.
REQ-021 HOLD never falls through to PCplus4F; the pending redirect is never lost.
REQ-022 RedirectPend = 1 exactly while in HOLD.
REQ-023 Applied target: bits [1:0] forced to 0; MisalignF = 1 for one cycle, aligned with the PCF update, if the original bits were nonzero.
REQ-024 PCplus4F wraps modulo 2^XLEN; no overflow flag.
REQ-025 Simultaneous TrapE and PCSrcE: trap target wins; branch target is discarded.

Reset
REQ-026 rst=1 at any edge: PCF <= RESET_VEC, state <= RUN, pending register <= 0, MisalignF <= 0; rst overrides StallF and all redirects.
REQ-027 Reset in HOLD discards the pending redirect; first fetch after reset is RESET_VEC.

Configuration
REQ-028 Macro PC_TRAP_EN defined: TrapE/TrapVec ports exist with the priority in REQ-014.
REQ-029 PC_TRAP_EN undefined: TrapE/TrapVec ports are absent; the trap term is removed from all priority and capture logic; all other behaviour is identical.

Structure
REQ-030 Shared package riscv_pkg holds XLEN default, RESET_VEC default, the pc_state_t enum (RUN, HOLD) and PC_INCR = 4.
REQ-031 Sub-module pc_src_sel: combinational priority select and alignment; it outputs the selected target, a valid flag and a misalign flag. pc_gen holds only registers and the FSM.

Verification
REQ-032 rst=1 for 2 cycles, then release with StallF=0 -> PCF = 0x0, then 0x4, then 0x8 on successive cycles.
REQ-033 PCF = 0x10, pulse PCSrcE with JumpTarget_E = 0x100 -> next cycle PCF = 0x100, then 0x104.
REQ-034 StallF=1 for 3 cycles, PCSrcE pulse (target 0x200) in cycle 1 -> RedirectPend = 1 in cycles 2–3; PCF unchanged; after the stall releases, PCF = 0x200 and RedirectPend = 0.
REQ-035 TrapE (TrapVec = 0x80) and PCSrcE (target 0x300) in the same cycle -> PCF = 0x80 (PC_TRAP_EN build).
REQ-036 JumpTarget_E = 0x103 with PCSrcE -> PCF = 0x100; MisalignF = 1 for exactly one cycle.
REQ-037 Enter HOLD with pending target 0x400, assert rst while StallF=1 -> PCF = RESET_VEC; RedirectPend = 0; 0x400 is never fetched.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch-PC generator: default widths, reset vector,
// PC FSM state type and the sequential PC increment.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT      = 32;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INCR           = 4;

  // RUN: PC advances normally. HOLD: a redirect arrived during a stall and is parked.
  typedef enum logic {
    RUN,
    HOLD
  } pc_state_t;

endpackage

// File: rtl/pc_src_sel.sv
// Combinational PC source selection for pc_gen.
// Priority: trap, branch/jump, parked redirect, PC+4. Redirect targets are
// word-aligned on the way out and a misalign flag reports dropped low bits.
// Optional build macro: PC_TRAP_EN adds the trap request/vector inputs.
module pc_src_sel
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
`ifdef PC_TRAP_EN
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
`endif
  input  logic            branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            pend_valid,
  input  logic [XLEN-1:0] pend_target,
  input  logic [XLEN-1:0] pc_plus4,
  output logic            new_valid,
  output logic [XLEN-1:0] new_target,
  output logic            sel_valid,
  output logic [XLEN-1:0] sel_target,
  output logic            sel_misalign
);

  logic [XLEN-1:0] raw_target;

  // New redirect this cycle (trap beats branch), then the applied source.
  always_comb begin
    new_valid    = 1'b0;
    new_target   = branch_target;
    raw_target   = pc_plus4;
    sel_valid    = 1'b0;
    sel_target   = pc_plus4;
    sel_misalign = 1'b0;

`ifdef PC_TRAP_EN
    if (trap) begin
      new_valid  = 1'b1;
      new_target = trap_vec;
    end else if (branch) begin
      new_valid  = 1'b1;
      new_target = branch_target;
    end
`else
    if (branch) begin
      new_valid  = 1'b1;
      new_target = branch_target;
    end
`endif

    if (new_valid) begin
      raw_target = new_target;
      sel_valid  = 1'b1;
    end else if (pend_valid) begin
      raw_target = pend_target;
      sel_valid  = 1'b1;
    end

    // Only redirect targets are realigned; the PC+4 path is already aligned.
    if (sel_valid) begin
      sel_target   = {raw_target[XLEN-1:2], 2'b00};
      sel_misalign = |raw_target[1:0];
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: PC register, parked-redirect register and RUN/HOLD FSM.
// A redirect seen while fetch is stalled is parked and applied when the stall
// releases, so it can never be lost or overtaken by PC+4.
// Optional build macro: PC_TRAP_EN adds TrapE/TrapVec with top priority.
module pc_gen
  import riscv_pkg::*;
#(
  parameter int unsigned    XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] JumpTarget_E,
`ifdef PC_TRAP_EN
  input  logic            TrapE,
  input  logic [XLEN-1:0] TrapVec,
`endif
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCplus4F,
  output logic            RedirectPend,
  output logic            MisalignF
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            mis_q, mis_d;

  logic            new_valid;
  logic [XLEN-1:0] new_target;
  logic            sel_valid;
  logic [XLEN-1:0] sel_target;
  logic            sel_misalign;

  assign PCF          = pc_q;
  assign PCplus4F     = pc_q + XLEN'(PC_INCR);
  assign RedirectPend = (state_q == HOLD);
  assign MisalignF    = mis_q;

  pc_src_sel #(
    .XLEN(XLEN)
  ) u_src_sel (
`ifdef PC_TRAP_EN
    .trap         (TrapE),
    .trap_vec     (TrapVec),
`endif
    .branch       (PCSrcE),
    .branch_target(JumpTarget_E),
    .pend_valid   (state_q == HOLD),
    .pend_target  (pend_q),
    .pc_plus4     (PCplus4F),
    .new_valid    (new_valid),
    .new_target   (new_target),
    .sel_valid    (sel_valid),
    .sel_target   (sel_target),
    .sel_misalign (sel_misalign)
  );

  // State registers with synchronous reset; reset drops any parked redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state: advance/redirect when not stalled, otherwise park new redirects.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    mis_d   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (!StallF) begin
          pc_d  = sel_target;
          mis_d = sel_misalign;
        end else if (new_valid) begin
          pend_d  = new_target;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!StallF) begin
          // sel_valid is always set here: the parked target is a fallback source.
          pc_d    = sel_target;
          mis_d   = sel_misalign & sel_valid;
          state_d = RUN;
        end else if (new_valid) begin
          pend_d = new_target;
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule
